// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier using the shift-and-add method.
// An operation starts when ld is sampled high in IDLE and takes WIDTH BUSY
// cycles, one partial product per cycle. The result is then held in DONE
// until the initiator drops ld. All outputs come straight from flops.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mult1,
  input  logic [WIDTH-1:0]   mult2,
  input  logic               ld,
  output logic [2*WIDTH-1:0] mult_res,
  output logic               mult_ok,
  output logic               busy
);

  // The counter only needs to reach WIDTH-1, because the last step is
  // identified by its pre-step count.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               ok_q, ok_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_step;

  // Accumulator value after the current step, shared by the accumulator
  // update and the final result capture so both see the last addition.
  always_comb begin
    acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
  end

  // Next-state and datapath control; flags are derived from the next state
  // so they can be registered alongside it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    unique case (state_q)
      IDLE: begin
        if (ld) begin
          a_d     = {{WIDTH{1'b0}}, mult1};
          b_d     = mult2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = acc_step;
          state_d = DONE;
        end
      end
      DONE: begin
        // Leaving DONE requires ld low, so a held ld cannot retrigger.
        if (!ld) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == BUSY);
    ok_d   = (state_d == DONE);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
    end
  end

  assign mult_res = res_q;
  assign mult_ok  = ok_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Testbench for shift_add_mult: directed scenarios plus randomized
// operations, checked through a scoreboard queue and a separate monitor.
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   mult1 = '0;
  logic [W-1:0]   mult2 = '0;
  logic           ld = 1'b0;
  logic [2*W-1:0] mult_res;
  logic           mult_ok;
  logic           busy;

  typedef struct {
    logic [2*W-1:0] prod;
    int             load_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .mult1(mult1), .mult2(mult2), .ld(ld),
    .mult_res(mult_res), .mult_ok(mult_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented, tracks
  // busy pulse length and result stability while mult_ok is held.
  int             busy_run = 0;
  bit             busy_prev = 0;
  bit             ok_prev = 0;
  logic [2*W-1:0] held_res = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy_run  = 0;
      busy_prev = 0;
      ok_prev   = 0;
    end else begin
      if (busy) busy_run++;
      else if (busy_prev) begin
        chk("busy_len", busy_run, 8);
        busy_run = 0;
      end
      if (busy && mult_ok) chk("busy_ok_exclusive", 1, 0);
      if (mult_ok && !ok_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ok", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("op result=%04h expected=%04h latency_edges=%0d",
                   mult_res, e.prod, edge_cnt - e.load_edge + 1);
          chk("product", mult_res, e.prod);
          chk("latency", edge_cnt - e.load_edge, 8);
        end
        held_res = mult_res;
      end else if (mult_ok && ok_prev && mult_res !== held_res) begin
        chk("done_res_stable", mult_res, held_res);
      end
      busy_prev = busy;
      ok_prev   = mult_ok;
    end
  end

  task automatic wait_ok();
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (mult_ok) got = 1;
    end
    if (!got) chk("timeout_mult_ok", 0, 1);
  endtask

  // mode 0: hold ld until done, then drop it
  // mode 1: drop ld (and scramble operands) right after the load edge
  // mode 2: hold ld, change operands to 0xFF right after the load edge
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    exp_t e;
    logic [2*W-1:0] p;
    p = 16'(a) * 16'(b);
    @(negedge clk);
    mult1 = a; mult2 = b; ld = 1'b1;
    e.prod = p; e.load_edge = edge_cnt + 1;
    sb.push_back(e);
    if (mode == 1) begin
      @(negedge clk);
      ld = 1'b0; mult1 = W'($urandom); mult2 = W'($urandom);
    end else if (mode == 2) begin
      @(negedge clk);
      mult1 = 8'hFF; mult2 = 8'hFF;
    end
    wait_ok();
    if (mode == 1) begin
      @(posedge clk); #1;
      chk("done_one_cycle", mult_ok, 0);
    end else begin
      @(negedge clk); ld = 1'b0;
      @(posedge clk); #1;
      chk("ok_drop", mult_ok, 0);
    end
    chk("res_hold_idle", mult_res, p);
  endtask

  initial begin
    int okc, bz;
    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 reset = 1'b1;
    #1;
    chk("reset_res", mult_res, 0);
    chk("reset_ok", mult_ok, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ok", mult_ok, 0);

    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'hA5, 0);
    run_op(8'h80, 8'h02, 0);
    run_op(8'h80, 8'hC8, 0);
    run_op(8'h80, 8'hFF, 0);
    run_op(8'h80, 8'h00, 0);
    run_op(8'h80, 8'h7F, 0);
    run_op(8'h12, 8'h34, 2);
    run_op(8'h01, 8'h01, 1);

    // ld held for 30 edges after one load: a single operation only.
    @(negedge clk);
    mult1 = 8'd3; mult2 = 8'd5; ld = 1'b1;
    begin
      exp_t e;
      e.prod = 16'h000F; e.load_edge = edge_cnt + 1;
      sb.push_back(e);
    end
    okc = 0; bz = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (i >= 9 && mult_ok) okc++;
      if (i > 9 && busy) bz++;
    end
    chk("hold_ok_cycles", okc, 22);
    chk("hold_no_rebusy", bz, 0);
    chk("hold_res", mult_res, 16'h000F);
    @(negedge clk) ld = 1'b0;
    @(posedge clk); #1;
    chk("hold_ok_drop", mult_ok, 0);

    // Reset four cycles into BUSY: immediate clear, no result ever appears.
    @(negedge clk);
    mult1 = 8'hFF; mult2 = 8'hFF; ld = 1'b1;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_res", mult_res, 0);
    chk("abort_ok", mult_ok, 0);
    chk("abort_busy", busy, 0);
    sb.delete();
    ld = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    okc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (mult_ok || busy) okc++;
    end
    chk("abort_quiet", okc, 0);
    run_op(8'h02, 8'h03, 0);

    // Randomized operations with random initiator behaviour.
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width; the result is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mult1  input  WIDTH  multiplicand (unsigned).
REQ-005 SHALL have port mult2  input  WIDTH  multiplier (unsigned).
REQ-006 SHALL have port ld  input  1  load request from the initiator, level-sensitive.
REQ-007 SHALL have port mult_res  output  2*WIDTH  registered product.
REQ-008 SHALL have port mult_ok  output  1  registered result-valid / done flag.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress (state BUSY).

Function
REQ-010 SHALL implement a state machine with the states IDLE, BUSY and DONE.
REQ-011 In IDLE, when ld=1 is sampled, SHALL perform the following on the same edge:
  - latch mult1 into a 2*WIDTH zero-extended shift register A;
  - latch mult2 into a WIDTH shift register B;
  - clear accumulator ACC and iteration counter CNT;
  - enter BUSY.
REQ-012 In IDLE with ld=0, SHALL remain in IDLE with mult_ok=0.
REQ-013 Each BUSY cycle SHALL perform one shift-add step, using the pre-step values of A and B:
  - if B[0]=1, ACC <= ACC + A, otherwise ACC unchanged;
  - A <= A<<1;
  - B <= B>>1;
  - CNT <= CNT+1.
REQ-014 SHALL spend exactly WIDTH cycles in BUSY.
  - On the edge completing step WIDTH-1: mult_res <= final ACC (including that step's addition), mult_ok <= 1, enter DONE.
REQ-015 Latency: mult_ok SHALL be observed high after the (WIDTH+1)th rising edge counted from, and including, the edge that sampled ld=1 in IDLE (9 edges for WIDTH=8).
REQ-016 ACC arithmetic SHALL be 2*WIDTH bits unsigned; the full product never overflows, so no saturation or truncation is required.
REQ-017 mult1, mult2 and ld changes during BUSY SHALL be ignored; the operation always completes with the operands latched at load.
REQ-018 In DONE, mult_ok SHALL stay 1 and mult_res stable until ld=0 is sampled; on that edge mult_ok <= 0 and the block enters IDLE.
REQ-019 If ld is already 0 on arrival in DONE (ld dropped during BUSY), DONE SHALL last exactly one cycle.
REQ-020 ld held high continuously through DONE SHALL NOT retrigger an operation; a new load requires ld to be sampled 0 (DONE->IDLE) and then 1 in IDLE.
REQ-021 mult_res SHALL hold the last completed product through IDLE and the next BUSY period, until the next completion overwrites it.
REQ-022 busy SHALL be 1 exactly in BUSY; mult_ok SHALL be 1 exactly in DONE.
REQ-023 Both busy and mult_ok SHALL be registered, with no combinational path from any input.
REQ-024 Unreachable state encodings SHALL recover to IDLE on the next clock edge.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE;
  - mult_res=0, mult_ok=0, busy=0;
  - A, B, ACC and CNT to 0.
REQ-026 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no partial result SHALL appear on mult_res.
REQ-027 After reset deasserts, the first ld=1 sampled in IDLE SHALL start a normal operation.

Verification
REQ-028 WIDTH=8, mult1=0xFF, mult2=0xFF, ld=1 held -> 9 edges later mult_ok=1, mult_res=0xFE01; drop ld -> mult_ok=0 on the next edge, mult_res stays 0xFE01.
REQ-029 mult1=0x00, mult2=0xA5, then mult1=0x80, mult2=0x02 -> mult_res=0x0000, then 0x0100; busy high for exactly 8 cycles per operation.
REQ-030 Initiator-style back-to-back sequence (raise ld only when mult_ok=0; drop ld on the edge mult_ok is seen) with operand pairs (0x80,0xC8),(0x80,0xFF),(0x80,0x00),(0x80,0x7F) -> results 0x6400, 0x7F80, 0x0000, 0x3F80 in order, with no missed or duplicate operations.
REQ-031 Operands 0x12 x 0x34 loaded, mult1/mult2 changed to 0xFF on the edge after load -> mult_res=0x03A8.
REQ-032 ld held high for 30 cycles after one load of 3 x 5 -> exactly one operation, mult_ok high from edge 9 through edge 30, mult_res=0x000F; busy never reasserts.
REQ-033 Reset pulsed 4 cycles into BUSY (operands 0xFF x 0xFF) -> outputs 0 immediately, mult_ok never rises; a subsequent load of 0x02 x 0x03 yields 0x0006 after 9 edges.
